lfsr_rr_arbiter: RTL

LFSR_RR_ARBITER -- requirements
Module: lfsr_rr_arbiter

---
 rtl/lfsr_arb_pkg.sv | 7 +
 rtl/lfsr_step.sv | 19 +
 rtl/lfsr_rr_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/lfsr_arb_pkg.sv
// lfsr_arb_pkg: shared FSM states, lockup seed and tap positions for lfsr_rr_arbiter
package lfsr_arb_pkg;
  typedef enum logic [1:0] {SEED, IDLE, GRANT} state_t;
  localparam logic [3:0] LOCKUP = 4'hF;
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 2;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: XNOR Fibonacci LFSR register with synchronous load and step enable
module lfsr_step import lfsr_arb_pkg::*; #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(4'h1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] nxt;
  assign nxt = {q[WIDTH-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= DEFAULT_SEED;
    else if (load) q <= load_val;
    else if (en) q <= nxt;
endmodule

// File: rtl/lfsr_rr_arbiter.sv
// lfsr_rr_arbiter: round-robin arbiter handing out LFSR values, one grant per two cycles
// Optional grant counter output gnt_cnt enabled by LFSR_ARB_GRANT_CNT_EN.
module lfsr_rr_arbiter import lfsr_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(4'h1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   rnd_data,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed,
  output logic               busy
`ifdef LFSR_ARB_GRANT_CNT_EN
  ,
  output logic [15:0]        gnt_cnt
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state;
  logic [WIDTH-1:0] pend, lfsr_q;
  logic [IW-1:0] ptr, pick, cand, ptr_nxt;
  // Scan downward so the closest requester at or after ptr wins last.
  always_comb begin
    pick = ptr;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) pick = cand;
    end
  end
  assign ptr_nxt = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
  lfsr_step #(.WIDTH(WIDTH), .DEFAULT_SEED(DEFAULT_SEED)) u_step (
    .clk(clk),
    .rst_n(rst_n),
    .load(state == SEED),
    .en(state == GRANT && !seed_load),
    .load_val(pend),
    .q(lfsr_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SEED;
      pend <= DEFAULT_SEED;
      ptr <= '0;
      gnt <= '0;
      rnd_data <= '0;
      busy <= 1'b1;
    end else begin
      gnt <= '0;
      rnd_data <= '0;
      busy <= 1'b0;
      if (seed_load) begin
        state <= SEED;
        pend <= (seed == WIDTH'(LOCKUP)) ? DEFAULT_SEED : seed;
        busy <= 1'b1;
      end else
        case (state)
          SEED: state <= IDLE;
          IDLE: if (|req) begin
            state <= GRANT;
            gnt <= NUM_REQ'(1) << pick;
            rnd_data <= lfsr_q;
            ptr <= ptr_nxt;
          end
          GRANT: state <= IDLE;
          default: state <= SEED;
        endcase
    end
`ifdef LFSR_ARB_GRANT_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) gnt_cnt <= '0;
    else if (seed_load) gnt_cnt <= '0;
    else if (state == IDLE && |req && gnt_cnt != 16'hFFFF) gnt_cnt <= gnt_cnt + 16'd1;
`endif
endmodule
